// File: rtl/packet_stats_sensor_pkg.sv
// Shared constants and helpers for the packet statistics sensor.
// Record word in the FIFO is {port, length, error}, error at bit 0.
package pkt_stats_defs;
  localparam int PORT_W       = 8;
  localparam int CNT_W        = 32;
  localparam int KMAX         = 128;
  localparam int REC_USER_BIT = 0;
  localparam int REC_LEN_LSB  = 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // tkeep is zero-extended to KMAX lanes by the caller
  function automatic logic [7:0] popcount(input logic [KMAX-1:0] v);
    logic [7:0] n;
    n = '0;
    for (int i = 0; i < KMAX; i++) n = n + 8'(v[i]);
    return n;
  endfunction
endpackage

// File: rtl/packet_stats_sensor_if.sv
// Monitored AXI stream tap and the record output stream.
interface pss_mon_if #(parameter int DW = 512);
  logic [DW-1:0]   tdata;
  logic [DW/8-1:0] tkeep;
  logic            tlast;
  logic            tvalid;
  logic            tuser;
  logic            tready;
  modport master (output tdata, tkeep, tlast, tvalid, tuser, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, tuser, output tready);
endinterface

interface pss_rec_if #(parameter int RW = 24);
  logic [RW-1:0] tdata;
  logic          tuser;
  logic          tvalid;
  logic          tready;
  modport master (output tdata, tuser, tvalid, input tready);
  modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/packet_stats_sensor_fifo.sv
// Synchronous FIFO whose head is held in an output register; write is accepted
// when not full or when a pop happens in the same cycle.
module pkt_stats_fifo #(
  parameter int W     = 25,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   wr_en,
  input  logic [W-1:0]           wr_data,
  output logic                   wr_ack,
  input  logic                   rd_en,
  output logic [W-1:0]           rd_data,
  output logic                   rd_valid,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [PW:0]   cnt_nxt;
  logic [W-1:0]  head_nxt;
  logic          pop;

  assign full    = count == (PW+1)'(DEPTH);
  assign empty   = count == '0;
  assign pop     = rd_en & rd_valid;
  assign wr_ack  = wr_en & (!full | pop);
  assign rd_nxt  = rd_ptr + PW'(pop);
  assign cnt_nxt = count + (PW+1)'(wr_ack) - (PW+1)'(pop);

  // the new head bypasses memory when it is the word being written
  always_comb begin
    head_nxt = '0;
    if (cnt_nxt != '0) head_nxt = (wr_ack && wr_ptr == rd_nxt) ? wr_data : mem[rd_nxt];
  end

  always_ff @(posedge clk) begin
    if (wr_ack) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      wr_ptr   <= wr_ptr + PW'(wr_ack);
      rd_ptr   <= rd_nxt;
      count    <= cnt_nxt;
      rd_data  <= head_nxt;
      rd_valid <= cnt_nxt != '0;
    end
  end
endmodule

// File: rtl/packet_stats_sensor.sv
// Passive RDMX packet monitor: {port,length,error} records into a FIFO plus per-port counters.
// Build option PKT_STATS_OVERSIZE_EN flags and counts packets longer than MAX_LEN.
module packet_stats_sensor
  import pkt_stats_defs::*;
#(
  parameter int DW         = 512,
  parameter int LW         = 16,
  parameter int HDR_BYTE   = 11,
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 16
`ifdef PKT_STATS_OVERSIZE_EN
  , parameter int MAX_LEN  = 9600
`endif
) (
  input  logic                      clk,
  input  logic                      resetn,
  pss_mon_if.slave                  monitor,
  pss_rec_if.master                 axis_out,
  input  logic [$clog2(NPORTS)-1:0] stat_sel,
  input  logic                      stat_clear,
  output logic [CNT_W-1:0]          stat_pkt_count,
  output logic [CNT_W-1:0]          stat_err_count,
  output logic [CNT_W-1:0]          stat_drop_count,
  output logic [CNT_W-1:0]          stat_badport_count
`ifdef PKT_STATS_OVERSIZE_EN
  , output logic [CNT_W-1:0]        stat_oversize_count
`endif
);
  localparam int KW  = DW / 8;
  localparam int KCW = $clog2(KW) + 1;
  localparam int SW  = $clog2(NPORTS);
  localparam int RW  = PORT_W + LW;

  logic              vld_q, last_q, user_q;
  logic [PORT_W-1:0] hdr_q, port_q, rec_port;
  logic [KCW-1:0]    kcnt_q;
  logic              in_pkt;
  logic [LW-1:0]     acc_q, len_n;
  logic [LW:0]       sum;
  logic              rec_vld, rec_user, port_ok, wr_ack;
  logic [RW:0]       fifo_q;

  logic [NPORTS-1:0][CNT_W-1:0] pkt_cnt, err_cnt;
  logic [CNT_W-1:0]             drop_cnt, bad_cnt;

  logic                    tdata_unused, fifo_full_unused, fifo_empty_unused;
  logic [$clog2(FIFO_DEPTH):0] fifo_count_unused;

  assign monitor.tready = resetn;
  // only the header byte of tdata is ever needed downstream
  assign tdata_unused   = ^monitor.tdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_q  <= 1'b0;
      last_q <= 1'b0;
      user_q <= 1'b0;
      hdr_q  <= '0;
      kcnt_q <= '0;
    end else begin
      vld_q  <= monitor.tvalid & monitor.tready;
      last_q <= monitor.tlast;
      user_q <= monitor.tuser;
      hdr_q  <= monitor.tdata[HDR_BYTE*8 +: PORT_W];
      kcnt_q <= KCW'(popcount(KMAX'(monitor.tkeep)));
    end
  end

  assign sum      = {1'b0, (in_pkt ? acc_q : {LW{1'b0}})} + (LW+1)'(kcnt_q);
  assign len_n    = sum[LW] ? {LW{1'b1}} : sum[LW-1:0];
  assign rec_port = in_pkt ? port_q : hdr_q;
  assign rec_vld  = vld_q & last_q;
  assign port_ok  = rec_port < PORT_W'(NPORTS);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      in_pkt <= 1'b0;
      acc_q  <= '0;
      port_q <= '0;
    end else if (vld_q) begin
      if (last_q) begin
        in_pkt <= 1'b0;
        acc_q  <= '0;
      end else begin
        in_pkt <= 1'b1;
        acc_q  <= len_n;
        if (!in_pkt) port_q <= hdr_q;
      end
    end
  end

`ifdef PKT_STATS_OVERSIZE_EN
  logic             ovs;
  logic [CNT_W-1:0] ovs_cnt;
  assign ovs      = {{(CNT_W-LW){1'b0}}, len_n} > CNT_W'(MAX_LEN);
  assign rec_user = user_q | ovs;

  always_ff @(posedge clk) begin
    if (!resetn || stat_clear) ovs_cnt <= '0;
    else if (rec_vld && ovs)   ovs_cnt <= sat_inc(ovs_cnt);
  end

  always_ff @(posedge clk) begin
    if (!resetn) stat_oversize_count <= '0;
    else         stat_oversize_count <= ovs_cnt;
  end
`else
  assign rec_user = user_q;
`endif

  pkt_stats_fifo #(.W(RW + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .wr_en    (rec_vld),
    .wr_data  ({rec_port, len_n, rec_user}),
    .wr_ack   (wr_ack),
    .rd_en    (axis_out.tready),
    .rd_data  (fifo_q),
    .rd_valid (axis_out.tvalid),
    .count    (fifo_count_unused),
    .full     (fifo_full_unused),
    .empty    (fifo_empty_unused)
  );

  assign axis_out.tdata = fifo_q[RW:REC_LEN_LSB];
  assign axis_out.tuser = fifo_q[REC_USER_BIT];

  // clear wins over a packet completing in the same cycle
  always_ff @(posedge clk) begin
    if (!resetn || stat_clear) begin
      pkt_cnt  <= '0;
      err_cnt  <= '0;
      drop_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      for (int p = 0; p < NPORTS; p++) begin
        if (rec_vld && port_ok && rec_port[SW-1:0] == SW'(p)) begin
          pkt_cnt[p] <= sat_inc(pkt_cnt[p]);
          if (user_q) err_cnt[p] <= sat_inc(err_cnt[p]);
        end
      end
      if (rec_vld && !port_ok) bad_cnt  <= sat_inc(bad_cnt);
      if (rec_vld && !wr_ack)  drop_cnt <= sat_inc(drop_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      stat_pkt_count     <= '0;
      stat_err_count     <= '0;
      stat_drop_count    <= '0;
      stat_badport_count <= '0;
    end else begin
      stat_pkt_count     <= pkt_cnt[stat_sel];
      stat_err_count     <= err_cnt[stat_sel];
      stat_drop_count    <= drop_cnt;
      stat_badport_count <= bad_cnt;
    end
  end
endmodule

// File: tb/tb_packet_stats_sensor.sv
// Directed bench for packet_stats_sensor: vector table of single packets plus
// hand sequences for FIFO overflow, clear collision, mid-packet reset and length saturation.
module tb_packet_stats_sensor;
  logic clk, resetn;
  logic [1:0]  stat_sel;
  logic        stat_clear;
  logic [31:0] stat_pkt_count, stat_err_count, stat_drop_count, stat_badport_count;
`ifdef PKT_STATS_OVERSIZE_EN
  logic [31:0] stat_oversize_count;
`endif

  pss_mon_if #(.DW(512)) mon ();
  pss_rec_if #(.RW(24))  rec ();

  packet_stats_sensor dut (
    .clk                (clk),
    .resetn             (resetn),
    .monitor            (mon),
    .axis_out           (rec),
    .stat_sel           (stat_sel),
    .stat_clear         (stat_clear),
    .stat_pkt_count     (stat_pkt_count),
    .stat_err_count     (stat_err_count),
    .stat_drop_count    (stat_drop_count),
    .stat_badport_count (stat_badport_count)
`ifdef PKT_STATS_OVERSIZE_EN
    , .stat_oversize_count (stat_oversize_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    int              nb;
    int              gap;
    logic [2:0][63:0] keep;
    logic [2:0][7:0]  pb;
    logic            user;
    logic [7:0]      e_port;
    int              e_len;
    logic            e_user;
  } vec_t;

  vec_t vecs [6];
  int n_tests = 0;
  int n_fail  = 0;

  function automatic vec_t mk(int nb, int gap, logic [63:0] k0, logic [63:0] k1, logic [63:0] k2,
                              logic [7:0] p0, logic [7:0] p1, logic [7:0] p2, logic user,
                              logic [7:0] ep, int el, logic eu);
    vec_t v;
    v.nb = nb; v.gap = gap;
    v.keep[0] = k0; v.keep[1] = k1; v.keep[2] = k2;
    v.pb[0] = p0; v.pb[1] = p1; v.pb[2] = p2;
    v.user = user; v.e_port = ep; v.e_len = el; v.e_user = eu;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic beat(input logic [63:0] keep, input logic [7:0] pb, input logic last, input logic user);
    mon.tdata = {16{$urandom}};
    mon.tdata[11*8 +: 8] = pb;
    mon.tkeep  = keep;
    mon.tlast  = last;
    mon.tuser  = user;
    mon.tvalid = 1'b1;
    @(posedge clk); #1;
    mon.tvalid = 1'b0;
  endtask

  task automatic idle();
    mon.tvalid = 1'b0;
    mon.tkeep  = '1;
    mon.tlast  = 1'b1;
    mon.tuser  = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic pop();
    rec.tready = 1'b1;
    @(posedge clk); #1;
    rec.tready = 1'b0;
  endtask

  task automatic rd(input int sel);
    stat_sel = 2'(sel);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  // called right after the tlast beat was taken: expects the record in the following cycle
  task automatic chk_rec(input string nm, input logic [7:0] port, input int len, input logic user);
    chk({nm, "_n1_valid"}, rec.tvalid, 0);
    @(posedge clk); #1;
    chk({nm, "_valid"}, rec.tvalid, 1);
    chk({nm, "_port"}, rec.tdata[23:16], port);
    chk({nm, "_len"}, rec.tdata[15:0], 64'(len));
    chk({nm, "_user"}, rec.tuser, user);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [63:0] k;
    logic        sat_user;

    vecs[0] = mk(3, 0, '1, '1, 64'hF, 8'h02, 8'h99, 8'h99, 1'b0, 8'h02, 132, 1'b0);
    vecs[1] = mk(1, 0, 64'h1, 0, 0, 8'h01, 0, 0, 1'b1, 8'h01, 1, 1'b1);
    vecs[2] = mk(1, 0, '1, 0, 0, 8'h07, 0, 0, 1'b0, 8'h07, 64, 1'b0);
    vecs[3] = mk(2, 0, 64'h0, 64'hFF, 0, 8'h03, 8'h55, 0, 1'b0, 8'h03, 8, 1'b0);
    vecs[4] = mk(1, 0, 64'h0, 0, 0, 8'h00, 0, 0, 1'b0, 8'h00, 0, 1'b0);
    vecs[5] = mk(2, 2, 64'hAAAA_AAAA_AAAA_AAAA, 64'h3, 0, 8'h01, 8'h02, 0, 1'b1, 8'h01, 34, 1'b1);

    resetn = 1'b0; stat_sel = '0; stat_clear = 1'b0; rec.tready = 1'b0;
    mon.tdata = '0; mon.tkeep = '0; mon.tlast = 1'b0; mon.tvalid = 1'b0; mon.tuser = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", mon.tready, 0);
    chk("rst_tvalid", rec.tvalid, 0);
    chk("rst_tdata", rec.tdata, 0);
    chk("rst_tuser", rec.tuser, 0);
    chk("rst_pkt", stat_pkt_count, 0);
    chk("rst_drop", stat_drop_count, 0);
    chk("rst_bad", stat_badport_count, 0);
    resetn = 1'b1;
    @(posedge clk); #1;
    chk("run_tready", mon.tready, 1);

    for (int v = 0; v < 6; v++) begin
      for (int b = 0; b < vecs[v].nb; b++) begin
        if (b > 0) repeat (vecs[v].gap) idle();
        beat(vecs[v].keep[b], vecs[v].pb[b], b == vecs[v].nb - 1,
             (b == vecs[v].nb - 1) ? vecs[v].user : ~vecs[v].user);
      end
      chk_rec($sformatf("vec%0d", v), vecs[v].e_port, vecs[v].e_len, vecs[v].e_user);
      pop();
      chk($sformatf("vec%0d_popped", v), rec.tvalid, 0);
    end

    rd(0); chk("tbl_pkt0", stat_pkt_count, 1);
    rd(1); chk("tbl_pkt1", stat_pkt_count, 2); chk("tbl_err1", stat_err_count, 2);
    rd(2); chk("tbl_pkt2", stat_pkt_count, 1); chk("tbl_err2", stat_err_count, 0);
    rd(3); chk("tbl_pkt3", stat_pkt_count, 1);
    chk("tbl_bad", stat_badport_count, 1);
    chk("tbl_drop", stat_drop_count, 0);

    // overflow: 20 records into a 16-deep FIFO with the sink stalled
    stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
    for (int i = 0; i < 20; i++) begin
      k = (64'd1 << (i + 1)) - 64'd1;
      beat(k, 8'(i % 4), 1'b1, 1'b0);
    end
    idle(); idle();
    chk("ovf_head_len", rec.tdata[15:0], 1);
    rd(2);
    chk("ovf_drop", stat_drop_count, 4);
    chk("ovf_pkt2", stat_pkt_count, 5);
    rd(0); chk("ovf_pkt0", stat_pkt_count, 5);
    // write into a full FIFO together with a pop must be accepted
    beat(64'hFF_FFFF_FFFF, 8'h01, 1'b1, 1'b0);
    rec.tready = 1'b1; @(posedge clk); #1; rec.tready = 1'b0;
    rd(1);
    chk("full_pop_drop", stat_drop_count, 4);
    chk("full_pop_pkt1", stat_pkt_count, 6);
    for (int i = 1; i < 16; i++) begin
      chk($sformatf("drain%0d_len", i), rec.tdata[15:0], 64'(i + 1));
      chk($sformatf("drain%0d_port", i), rec.tdata[23:16], 64'(i % 4));
      pop();
    end
    chk("drain_last_len", rec.tdata[15:0], 40);
    chk("drain_last_port", rec.tdata[23:16], 1);
    pop();
    chk("drain_empty", rec.tvalid, 0);

    // clear coincident with a completing packet
    beat(64'h1, 8'h03, 1'b1, 1'b1);
    stat_clear = 1'b1; @(posedge clk); #1; stat_clear = 1'b0;
    chk("clr_rec_valid", rec.tvalid, 1);
    chk("clr_rec_port", rec.tdata[23:16], 3);
    chk("clr_rec_user", rec.tuser, 1);
    rd(3); chk("clr_pkt3", stat_pkt_count, 0); chk("clr_err3", stat_err_count, 0);
    rd(1); chk("clr_pkt1", stat_pkt_count, 0);
    chk("clr_drop", stat_drop_count, 0);
    chk("clr_bad", stat_badport_count, 0);
    pop();

    // reset after 2 of 4 beats; the aborted packet must leave no trace
    beat('1, 8'h03, 1'b0, 1'b0);
    beat('1, 8'h03, 1'b0, 1'b0);
    resetn = 1'b0;
    @(posedge clk); #1;
    chk("midrst_tready", mon.tready, 0);
    @(posedge clk); #1;
    resetn = 1'b1;
    beat(64'hFF, 8'h02, 1'b1, 1'b0);
    chk_rec("midrst", 8'h02, 8, 1'b0);
    pop();
    chk("midrst_single", rec.tvalid, 0);
    rd(2); chk("midrst_pkt2", stat_pkt_count, 1);
    rd(3); chk("midrst_pkt3", stat_pkt_count, 0);

    // 1025 full beats = 65600 bytes, saturates the 16-bit length
`ifdef PKT_STATS_OVERSIZE_EN
    sat_user = 1'b1;
`else
    sat_user = 1'b0;
`endif
    for (int b = 0; b < 1024; b++) beat('1, 8'h00, 1'b0, 1'b0);
    beat('1, 8'h00, 1'b1, 1'b0);
    chk_rec("sat", 8'h00, 65535, sat_user);
    pop();
`ifdef PKT_STATS_OVERSIZE_EN
    rd(0); chk("sat_oversize", stat_oversize_count, 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/packet_stats_sensor.md
Name: packet_stats_sensor

Overview:
- Passive monitor on a packetised AXI stream. Measures each packet's byte length and extracts its source port from the RDMX header.
- Pushes one {port, length, error} record per packet into an internal FIFO. The FIFO drives a back-pressurable output stream.
- Keeps per-port packet and error counters plus a record-drop counter, readable through a select/readback interface.
- Next-generation packet sensor for the RX path statistics block.

Parameters:
- DW, 512, monitored tdata width in bits; multiple of 8.
- LW, 16, packet length field width; length saturates at 2^LW-1.
- HDR_BYTE, 11, byte offset of the port-number byte in the first beat of each packet.
- NPORTS, 4, number of per-port counter banks; power of 2, 2..16.
- FIFO_DEPTH, 16, output record FIFO depth; power of 2, 4..64.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- monitor_tdata  in  DW  monitored data
- monitor_tkeep  in  DW/8  byte enables
- monitor_tlast  in  1  last beat of packet
- monitor_tvalid  in  1  beat valid
- monitor_tuser  in  1  packet error flag, sampled on the tlast beat
- monitor_tready  out  1  equals resetn; monitor never back-pressures
- axis_out_tdata  out  8+LW  {port[7:0], length[LW-1:0]}
- axis_out_tuser  out  1  error flag of the record
- axis_out_tvalid  out  1  record valid
- axis_out_tready  in  1  downstream accepts record
- stat_sel  in  log2(NPORTS)  counter bank select
- stat_clear  in  1  one-cycle pulse; zeroes all counters
- stat_pkt_count  out  32  packets seen on bank stat_sel
- stat_err_count  out  32  tuser=1 packets on bank stat_sel
- stat_drop_count  out  32  records lost to FIFO full
- stat_badport_count  out  32  packets with port >= NPORTS

Behaviour:
- Reset (resetn=0): all registers clear. axis_out_tvalid=0, tdata=0, tuser=0, all stat outputs=0, FIFO empty.
- Reset mid-packet: the partial packet is discarded. The first beat after reset is a packet start.
- Input stage:
  - Registers tdata, tlast, tuser and valid&ready.
  - Registers popcount(tkeep) as a $clog2(DW/8)+1-bit value.
- Packet start is tracked by an in_packet flag, not by accumulated length. A first beat with tkeep=0 still captures the port.
- On the registered first beat, port <= tdata[HDR_BYTE*8 +: 8].
- Length accumulator:
  - length = partial + keep_count, LW-bit, saturating at all-ones.
  - Beats with valid low are ignored.
- On the registered tlast beat: form the record {port, length, tuser}, clear the accumulator and in_packet, and attempt a FIFO write.
- A single-beat packet uses that same beat for both port and length.
- Latency: monitor tlast handshake in cycle N gives axis_out_tvalid=1 in cycle N+2, when the FIFO is empty.
- Output handshake:
  - Record held stable while tvalid=1 and tready=0.
  - Pop on tvalid&tready.
  - axis_out_* driven from FIFO registered outputs.
- FIFO full:
  - Write accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Otherwise the record is dropped and stat_drop_count increments.
- Counters, updated in the cycle the record forms, independent of whether the FIFO accepts it:
  - port<NPORTS: pkt_count[port]++; err_count[port]++ if tuser.
  - Else: badport_count++.
- All counters are 32-bit and saturate at 0xFFFFFFFF.
- stat_clear wins over a coincident increment; the packet completing that cycle is not counted.
- Readback: stat_* outputs are registered, valid one cycle after stat_sel changes.

Optional Feature:
- Macro PKT_STATS_OVERSIZE_EN.
- Defined:
  - Adds parameter MAX_LEN, default 9600.
  - Packets with length>MAX_LEN (saturated value) set axis_out_tuser=1.
  - Such packets also increment a new output stat_oversize_count (32, saturating, cleared by stat_clear).
- Undefined: port, parameter and logic absent; tuser passes monitor_tuser unchanged.

Decomposition:
- Package/header pkt_stats_defs:
  - Record field offsets, PORT_W=8, counter width 32.
  - Saturating-increment function and popcount function.
- Sub-module pkt_stats_fifo: synchronous FIFO, parameterised width/depth, with registered outputs and count, full and empty.

Test Plan:
- 3-beat packet, tkeep all-ones, all-ones, 0x000F, byte 11 = 0x02 -> record {0x02, 132}, tuser 0, at N+2; pkt_count[2]=1.
- Single beat, tkeep=0x1, tuser=1, port 0x01 -> record {0x01, 1}, tuser 1; err_count[1]=1.
- Hold axis_out_tready=0, send 20 one-beat packets, FIFO_DEPTH=16 -> 16 records retained in order, stat_drop_count=4, pkt_count total 20.
- Port byte 0x07 with NPORTS=4 -> record carries 0x07; stat_badport_count=1; per-port counters unchanged.
- Assert resetn=0 mid-packet (after 2 of 4 beats), then send a fresh 1-beat packet, tkeep=0xFF -> single record with length 8, no record for the aborted packet.
- Pulse stat_clear in the same cycle a packet completes -> all counters 0 next cycle; record still emitted to axis_out.
